// File: rtl/frontend_pkg.sv
// Shared frontend definitions: predecode control-flow classes and RAS sizing.
package frontend_pkg;

  typedef enum logic [3:0] {
    NOT_CFLOW  = 4'd0,
    IS_COND_BR = 4'd1,
    IS_RET     = 4'd2,
    IS_J       = 4'd3,
    IS_JR      = 4'd4,
    IS_JAL     = 4'd5,
    IS_JALR    = 4'd6,
    IS_JALR_CO = 4'd7
  } jump_t;

  localparam int RAS_DEPTH = 8;
  localparam int N_PD_BITS = 4;

endpackage

// File: rtl/ras_storage.sv
// Return-address entry array: one synchronous write port, one combinational read port.
module ras_storage #(
  parameter int DEPTH = 8,
  parameter int PTR_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [PTR_W-1:0] waddr,
  input  logic [63:0]      wdata,
  input  logic [PTR_W-1:0] raddr,
  output logic [63:0]      rdata
);

  logic [63:0] mem [DEPTH];

  // Contents are deliberately left unreset; occupancy tracking makes stale entries harmless.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/ras_ctrl.sv
// Return-address-stack controller: decodes predecode classes into push/pop/swap on a
// circular stack, registers the predicted return target, and supports checkpoint repair.
module ras_ctrl
  import frontend_pkg::*;
#(
  parameter int DEPTH = RAS_DEPTH,
  parameter int PD_W  = N_PD_BITS,
  parameter int PTR_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             pd_valid,
  input  logic [PD_W-1:0]  pd_type,
  input  logic [63:0]      pd_pc,
  input  logic             restore,
  input  logic [PTR_W-1:0] restore_tos,
  input  logic [PTR_W:0]   restore_cnt,
  output logic [PTR_W-1:0] ckpt_tos,
  output logic [PTR_W:0]   ckpt_cnt,
  output logic             pred_valid,
  output logic [63:0]      pred_target,
  output logic             ras_empty,
  output logic             ras_full
);

  localparam int                 CNT_W   = PTR_W + 1;
  localparam logic [CNT_W-1:0]   CNT_MAX = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0]   CNT_ONE = CNT_W'(1);
  localparam logic [PTR_W-1:0]   PTR_ONE = PTR_W'(1);

  localparam logic [PD_W-1:0] PD_RET     = PD_W'(IS_RET);
  localparam logic [PD_W-1:0] PD_JAL     = PD_W'(IS_JAL);
  localparam logic [PD_W-1:0] PD_JALR    = PD_W'(IS_JALR);
  localparam logic [PD_W-1:0] PD_JALR_CO = PD_W'(IS_JALR_CO);

  logic [PTR_W-1:0] tos_q, tos_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             pred_valid_p1, pred_valid_d;
  logic [63:0]      pred_target_p1, pred_target_d;

  logic             wr_en;
  logic [PTR_W-1:0] wr_addr;
  logic [63:0]      rd_data;
  logic [63:0]      link;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    return (c == CNT_MAX) ? c : c + CNT_ONE;
  endfunction

  function automatic logic [CNT_W-1:0] clamp_cnt(input logic [CNT_W-1:0] c);
    return (c > CNT_MAX) ? CNT_MAX : c;
  endfunction

  assign link = pd_pc + 64'd4;

  ras_storage #(.DEPTH(DEPTH), .PTR_W(PTR_W)) u_storage (
    .clk   (clk),
    .we    (wr_en),
    .waddr (wr_addr),
    .wdata (link),
    .raddr (tos_q),
    .rdata (rd_data)
  );

  // Stage p0: decode the predecoded class into the next stack state and entry write.
  always_comb begin
    tos_d         = tos_q;
    cnt_d         = cnt_q;
    pred_valid_d  = 1'b0;
    pred_target_d = pred_target_p1;
    wr_en         = 1'b0;
    wr_addr       = tos_q + PTR_ONE;
    if (restore) begin
      tos_d = restore_tos;
      cnt_d = clamp_cnt(restore_cnt);
    end else if (pd_valid) begin
      case (pd_type)
        PD_JAL, PD_JALR: begin
          tos_d = tos_q + PTR_ONE;
          cnt_d = sat_inc(cnt_q);
          wr_en = 1'b1;
        end
        PD_RET: begin
          if (cnt_q != '0) begin
            pred_valid_d  = 1'b1;
            pred_target_d = rd_data;
            tos_d         = tos_q - PTR_ONE;
            cnt_d         = cnt_q - CNT_ONE;
          end
        end
        PD_JALR_CO: begin
          if (cnt_q == '0) begin
            tos_d = tos_q + PTR_ONE;
            cnt_d = sat_inc(cnt_q);
            wr_en = 1'b1;
          end else begin
            // Read of entry[tos] happens before the same-cycle overwrite with the link.
            pred_valid_d  = 1'b1;
            pred_target_d = rd_data;
            wr_en         = 1'b1;
            wr_addr       = tos_q;
          end
        end
        default: ;
      endcase
    end
  end

  // Stage p1: registered stack pointers and prediction.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tos_q          <= '0;
      cnt_q          <= '0;
      pred_valid_p1  <= 1'b0;
      pred_target_p1 <= '0;
    end else begin
      tos_q          <= tos_d;
      cnt_q          <= cnt_d;
      pred_valid_p1  <= pred_valid_d;
      pred_target_p1 <= pred_target_d;
    end
  end

  assign ckpt_tos    = tos_q;
  assign ckpt_cnt    = cnt_q;
  assign pred_valid  = pred_valid_p1;
  assign pred_target = pred_target_p1;
  assign ras_empty   = (cnt_q == '0);
  assign ras_full    = (cnt_q == CNT_MAX);

endmodule

// File: tb/tb_ras_ctrl.sv
// Scoreboard bench for ras_ctrl: directed stimulus queues expected predictions, a monitor checks them.
module tb_ras_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        pd_valid;
  logic [3:0]  pd_type;
  logic [63:0] pd_pc;
  logic        restore;
  logic [2:0]  restore_tos;
  logic [3:0]  restore_cnt;
  logic [2:0]  ckpt_tos;
  logic [3:0]  ckpt_cnt;
  logic        pred_valid;
  logic [63:0] pred_target;
  logic        ras_empty;
  logic        ras_full;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  typedef struct {
    logic [63:0] tgt;
    int          at_cyc;
  } exp_t;
  exp_t sb[$];

  ras_ctrl #(.DEPTH(8), .PD_W(4)) dut (
    .clk         (clk),
    .reset       (reset),
    .pd_valid    (pd_valid),
    .pd_type     (pd_type),
    .pd_pc       (pd_pc),
    .restore     (restore),
    .restore_tos (restore_tos),
    .restore_cnt (restore_cnt),
    .ckpt_tos    (ckpt_tos),
    .ckpt_cnt    (ckpt_cnt),
    .pred_valid  (pred_valid),
    .pred_target (pred_target),
    .ras_empty   (ras_empty),
    .ras_full    (ras_full)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Every visible prediction must match the oldest queued expectation, on the expected cycle.
  always @(negedge clk) begin
    if (!reset && pred_valid) begin
      if (sb.size() == 0) begin
        chk("pred_unexpected", 64'(pred_valid), 64'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("pred_target", pred_target, e.tgt);
        chk("pred_cycle", 64'(cyc), 64'(e.at_cyc));
      end
    end
  end

  task automatic op(input logic [3:0] t, input logic [63:0] pc,
                    input bit exp_pred, input logic [63:0] tgt);
    @(negedge clk);
    pd_valid = 1'b1;
    pd_type  = t;
    pd_pc    = pc;
    restore  = 1'b0;
    if (exp_pred) sb.push_back('{tgt, cyc + 1});
  endtask

  task automatic idle();
    @(negedge clk);
    pd_valid = 1'b0;
    pd_type  = 4'd0;
    restore  = 1'b0;
  endtask

  task automatic do_restore(input logic [2:0] t, input logic [3:0] c, input bit with_ret);
    @(negedge clk);
    restore     = 1'b1;
    restore_tos = t;
    restore_cnt = c;
    pd_valid    = with_ret;
    pd_type     = 4'd2;
    pd_pc       = 64'h0BAD;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; pd_valid = 1'b0; pd_type = 4'd0; pd_pc = '0;
    restore = 1'b0; restore_tos = '0; restore_cnt = '0;
    repeat (3) @(posedge clk);
    @(negedge clk) reset = 1'b0;
    idle();
    chk("reset_tos", 64'(ckpt_tos), 64'd0);
    chk("reset_cnt", 64'(ckpt_cnt), 64'd0);
    chk("reset_pred_valid", 64'(pred_valid), 64'd0);
    chk("reset_pred_target", pred_target, 64'd0);
    chk("reset_empty", 64'(ras_empty), 64'd1);
    chk("reset_full", 64'(ras_full), 64'd0);

    // 1: two calls then two returns
    op(4'd5, 64'h1000, 0, 0);
    op(4'd5, 64'h2000, 0, 0);
    op(4'd2, 64'h0, 1, 64'h2004);
    op(4'd2, 64'h0, 1, 64'h1004);
    idle();
    chk("t1_empty", 64'(ras_empty), 64'd1);
    chk("t1_cnt", 64'(ckpt_cnt), 64'd0);

    // 2: return on an empty stack, plus non-stack classes
    op(4'd2, 64'h0, 0, 0);
    op(4'd1, 64'h10, 0, 0);
    op(4'd3, 64'h20, 0, 0);
    op(4'd4, 64'h30, 0, 0);
    op(4'd9, 64'h40, 0, 0);
    idle();
    chk("t2_tos", 64'(ckpt_tos), 64'd0);
    chk("t2_cnt", 64'(ckpt_cnt), 64'd0);
    chk("t2_pred_valid", 64'(pred_valid), 64'd0);
    chk("t2_target_hold", pred_target, 64'h1004);

    // 3: overflow by one, then drain
    for (int i = 1; i <= 8; i++) op(4'(5 + (i % 2)), 64'(i * 'h100), 0, 0);
    idle();
    chk("t3_full", 64'(ras_full), 64'd1);
    chk("t3_cnt8", 64'(ckpt_cnt), 64'd8);
    chk("t3_tos8", 64'(ckpt_tos), 64'd0);
    op(4'd5, 64'h900, 0, 0);
    idle();
    chk("t3_cnt_sat", 64'(ckpt_cnt), 64'd8);
    chk("t3_tos_wrap", 64'(ckpt_tos), 64'd1);
    for (int k = 1; k <= 8; k++) op(4'd2, 64'h0, 1, 64'((10 - k) * 'h100 + 4));
    op(4'd2, 64'h0, 0, 0);
    idle();
    chk("t3_empty", 64'(ras_empty), 64'd1);
    chk("t3_tos_end", 64'(ckpt_tos), 64'd1);

    // 4: co-routine swap
    op(4'd5, 64'h40, 0, 0);
    op(4'd7, 64'h80, 1, 64'h44);
    idle();
    chk("t4_cnt_swap", 64'(ckpt_cnt), 64'd1);
    op(4'd2, 64'h0, 1, 64'h84);
    idle();
    chk("t4_cnt_end", 64'(ckpt_cnt), 64'd0);
    op(4'd7, 64'hA0, 0, 0);
    idle();
    chk("t4_co_empty_push", 64'(ckpt_cnt), 64'd1);
    op(4'd2, 64'h0, 1, 64'hA4);

    // 5: checkpoint and repair
    op(4'd5, 64'h500, 0, 0);
    op(4'd6, 64'h600, 0, 0);
    idle();
    chk("t5_ckpt_tos", 64'(ckpt_tos), 64'd3);
    chk("t5_ckpt_cnt", 64'(ckpt_cnt), 64'd2);
    op(4'd5, 64'h300, 0, 0);
    do_restore(3'd3, 4'd2, 1);
    idle();
    chk("t5_rest_tos", 64'(ckpt_tos), 64'd3);
    chk("t5_rest_cnt", 64'(ckpt_cnt), 64'd2);
    chk("t5_rest_pv", 64'(pred_valid), 64'd0);
    op(4'd2, 64'h0, 1, 64'h604);
    do_restore(3'd5, 4'd15, 0);
    idle();
    chk("t5_clamp_cnt", 64'(ckpt_cnt), 64'd8);
    chk("t5_clamp_full", 64'(ras_full), 64'd1);
    chk("t5_clamp_tos", 64'(ckpt_tos), 64'd5);
    do_restore(3'd0, 4'd0, 0);
    idle();

    // 6: asynchronous reset mid-stream
    for (int i = 1; i <= 4; i++) op(4'd5, 64'(i * 'h10), 0, 0);
    op(4'd2, 64'h0, 1, 64'h44);
    op(4'd5, 64'h50, 0, 0);
    chk("t6_pre_cnt", 64'(ckpt_cnt), 64'd3);
    #2 reset = 1'b1;
    #1;
    chk("t6_async_cnt", 64'(ckpt_cnt), 64'd0);
    chk("t6_async_tos", 64'(ckpt_tos), 64'd0);
    chk("t6_async_pv", 64'(pred_valid), 64'd0);
    chk("t6_async_pt", pred_target, 64'd0);
    chk("t6_async_empty", 64'(ras_empty), 64'd1);
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0; pd_valid = 1'b0;
    op(4'd5, 64'h700, 0, 0);
    op(4'd2, 64'h0, 1, 64'h704);
    idle();
    idle();
    chk("t6_end_empty", 64'(ras_empty), 64'd1);
    chk("sb_drain", 64'(sb.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
